// File: rtl/dsm_channel_measure.sv
// dsm_channel_measure: measures one high and one low period of an asynchronous pin in clk cycles.
module dsm_channel_measure #(
   parameter int          CNT_WIDTH      = 16,
   parameter int          SYNC_STAGES    = 2,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 measure_start,
   input  logic                 measure_pin,
   output logic [CNT_WIDTH-1:0] high_time,
   output logic [CNT_WIDTH-1:0] low_time,
   output logic                 measure_done,
   output logic                 timeout,
   output logic                 overflow,
   output logic                 busy
);
   typedef enum logic [2:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW, DONE} state_t;
   localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   state_t state, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic pin_prev, start_q, armed;
   logic [CNT_WIDTH-1:0] cnt, high_hold;
   logic [31:0] tcnt;
   logic sync, rise, fall, start_ev, expire, cnt_max;
   assign sync     = sync_q[SYNC_STAGES-1];
   assign rise     = sync & ~pin_prev;
   assign fall     = ~sync & pin_prev;
   // armed blocks a start level that was already high when reset released
   assign start_ev = measure_start & ~start_q & armed;
   assign expire   = tcnt == TIMEOUT_CYCLES - 32'd1;
   assign cnt_max  = &cnt;
   assign busy     = state == WAIT_RISE || state == MEAS_HIGH || state == MEAS_LOW;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync_q   <= '0;
         pin_prev <= 1'b0;
         start_q  <= 1'b0;
         armed    <= 1'b0;
         state    <= IDLE;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], measure_pin};
         pin_prev <= sync;
         start_q  <= measure_start;
         armed    <= armed | ~measure_start;
         state    <= state_d;
      end
   always_comb begin
      state_d = state;
      case (state)
         IDLE:      state_d = start_ev ? WAIT_RISE : IDLE;
         WAIT_RISE: state_d = !measure_start ? IDLE : rise ? MEAS_HIGH : expire ? DONE : WAIT_RISE;
         MEAS_HIGH: state_d = !measure_start ? IDLE : fall ? MEAS_LOW : expire ? DONE : MEAS_HIGH;
         MEAS_LOW:  state_d = !measure_start ? IDLE : (rise || expire) ? DONE : MEAS_LOW;
         DONE:      state_d = measure_start ? DONE : IDLE;
         default:   state_d = IDLE;
      endcase
   end
   // high_hold keeps the high count private until the low phase closes, so an abort leaves results untouched
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt          <= '0;
         high_hold    <= '0;
         tcnt         <= '0;
         high_time    <= '0;
         low_time     <= '0;
         measure_done <= 1'b0;
         timeout      <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         tcnt         <= (state_d != state) ? '0 : tcnt + 32'd1;
         measure_done <= state == DONE && measure_start;
         case (state)
            IDLE:
               if (start_ev) begin
                  timeout  <= 1'b0;
                  overflow <= 1'b0;
               end
            WAIT_RISE:
               if (!measure_start) begin
                  timeout  <= 1'b0;
                  overflow <= 1'b0;
               end else if (rise) begin
                  cnt <= ONE;
               end else if (expire) begin
                  high_time <= '0;
                  low_time  <= '0;
                  timeout   <= 1'b1;
               end
            MEAS_HIGH:
               if (!measure_start) begin
                  timeout  <= 1'b0;
                  overflow <= 1'b0;
               end else if (fall) begin
                  high_hold <= cnt;
                  cnt       <= ONE;
               end else if (expire) begin
                  high_time <= cnt;
                  low_time  <= '0;
                  timeout   <= 1'b1;
               end else begin
                  cnt      <= cnt + {{(CNT_WIDTH-1){1'b0}}, ~cnt_max};
                  overflow <= overflow | cnt_max;
               end
            MEAS_LOW:
               if (!measure_start) begin
                  timeout  <= 1'b0;
                  overflow <= 1'b0;
               end else if (rise || expire) begin
                  high_time <= high_hold;
                  low_time  <= cnt;
                  timeout   <= ~rise;
               end else begin
                  cnt      <= cnt + {{(CNT_WIDTH-1){1'b0}}, ~cnt_max};
                  overflow <= overflow | cnt_max;
               end
            default: ;
         endcase
      end
endmodule

// File: doc/dsm_channel_measure.md
DSM_CHANNEL_MEASURE -- requirements
Module: dsm_channel_measure

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 16, the width of each result counter.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2 (minimum 2), the number of input synchronizer flops.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, the per-phase edge timeout in clk cycles (32-bit).
REQ-004 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port measure_start  input  1  level request from the channel handler; held high until done is seen.
REQ-007 The block SHALL have port measure_pin  input  1  asynchronous digital signal under test.
REQ-008 The block SHALL have port high_time  output  CNT_WIDTH  measured high-period length in clk cycles.
REQ-009 The block SHALL have port low_time  output  CNT_WIDTH  measured low-period length in clk cycles.
REQ-010 The block SHALL have port measure_done  output  1  result valid, level.
REQ-011 The block SHALL have port timeout  output  1  last measurement ended by timeout.
REQ-012 The block SHALL have port overflow  output  1  a count in the last measurement saturated.
REQ-013 The block SHALL have port busy  output  1  measurement in progress.

Function
REQ-014 measure_pin SHALL pass through SYNC_STAGES flops; one further flop (pin_prev) SHALL give rise = sync & ~pin_prev and fall = ~sync & pin_prev.
REQ-015 A start event SHALL be measure_start 1 with its registered copy 0; a level already high at reset release SHALL NOT start.
REQ-016 The block SHALL have states IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW, DONE.
REQ-017 IDLE -> WAIT_RISE on start event; clear timeout, overflow, measure_done; results unchanged.
REQ-018 WAIT_RISE -> MEAS_HIGH on rise; counter loads 1; a pin already high at start SHALL be ignored until a true rising edge.
REQ-019 MEAS_HIGH: counter +1 per cycle; on fall latch high_time = counter, load counter 1, -> MEAS_LOW.
REQ-020 MEAS_LOW: counter +1 per cycle; on rise latch low_time = counter, -> DONE.
REQ-021 A pin high for N synchronized samples SHALL yield high_time = N; the same rule applies to low_time.
REQ-022 The counter SHALL saturate at 2^CNT_WIDTH-1 and set overflow; it SHALL never wrap.
REQ-023 A timeout counter SHALL clear on entry to WAIT_RISE, MEAS_HIGH and MEAS_LOW and count each cycle; on reaching TIMEOUT_CYCLES-1 the block SHALL latch the current phase count (unstarted phases = 0), set timeout and go -> DONE.
REQ-024 In WAIT_RISE a timeout SHALL report high_time = 0 and low_time = 0.
REQ-025 If an edge and timeout expiry coincide, the edge SHALL win.
REQ-026 DONE: measure_done = 1 from the cycle after entry; it SHALL hold until measure_start = 0, then -> IDLE with measure_done = 0.
REQ-027 Results and flags SHALL stay stable from measure_done rise until the next start event, so the handler can upload after dropping start.
REQ-028 measure_start = 0 in WAIT_RISE, MEAS_HIGH or MEAS_LOW SHALL abort -> IDLE: no done, results unchanged, timeout and overflow cleared.
REQ-029 busy = 1 in WAIT_RISE, MEAS_HIGH and MEAS_LOW only.
REQ-030 Latency: measure_done SHALL rise SYNC_STAGES+2 cycles after the pin edge that closes the low period.

Reset
REQ-031 rst_n = 0 SHALL force IDLE; all outputs, counters, synchronizer flops and the start register SHALL go to 0 immediately, including mid-measurement.
REQ-032 After reset release the block SHALL require a fresh start event.

Verification
REQ-033 Square wave high 10 / low 30 cycles, start asserted -> high_time = 10, low_time = 30, done = 1, timeout = 0, overflow = 0.
REQ-034 TIMEOUT_CYCLES = 100, pin held 0 -> done about 100 cycles after start, timeout = 1, high_time = 0, low_time = 0.
REQ-035 Pin high 70000 cycles then low 5, TIMEOUT_CYCLES = 1e6 -> high_time = 0xFFFF, low_time = 5, overflow = 1.
REQ-036 Pin already high at start, then low 8 / high 12 / low 20 / high -> high_time = 12, low_time = 20.
REQ-037 start dropped in MEAS_HIGH -> no done, previous results held; new start -> correct new results.
REQ-038 rst_n pulsed in MEAS_LOW -> all outputs 0 at once; start held high through release -> no measurement until start toggles.
